otg_hpi_bus_master: RTL



---
 rtl/otg_hpi_bus_master_if.sv | 35 +++
 rtl/otg_hpi_bus_master.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/otg_hpi_bus_master_if.sv
// Avalon-MM slave and CY7C67200 HPI pin bundle for otg_hpi_bus_master.
// Handshake: a transfer is requested while chipselect & (read | write) and completes
// in the one cycle where waitrequest is low; the requester holds address, direction
// and writedata stable until then.
interface otg_hpi_bus_master_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [1:0]  otg_hpi_address;
    logic        otg_hpi_cs_n;
    logic        otg_hpi_r_n;
    logic        otg_hpi_w_n;
    logic [15:0] otg_hpi_data_out;
    logic        otg_hpi_data_oe;
    logic [15:0] otg_hpi_data_in;
    logic        otg_hpi_int;
    logic        irq;
    logic [2:0]  fsm_state;

    modport slave (
        input  address, chipselect, read, write, writedata, otg_hpi_data_in, otg_hpi_int,
        output readdata, waitrequest, otg_hpi_address, otg_hpi_cs_n, otg_hpi_r_n,
               otg_hpi_w_n, otg_hpi_data_out, otg_hpi_data_oe, irq, fsm_state
    );

    modport master (
        output address, chipselect, read, write, writedata, otg_hpi_data_in, otg_hpi_int,
        input  readdata, waitrequest, otg_hpi_address, otg_hpi_cs_n, otg_hpi_r_n,
               otg_hpi_w_n, otg_hpi_data_out, otg_hpi_data_oe, irq, fsm_state
    );
endinterface

// File: rtl/otg_hpi_bus_master.sv
// Turns each Avalon word access into one timed HPI bus cycle (setup/strobe/hold).
// Optional OTG_HPI_INT_SYNC_EN: 2-flop synchronizer from otg_hpi_int to irq.
module otg_hpi_bus_master #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
) (
    input logic               clk,
    input logic               reset,
    otg_hpi_bus_master_if.slave bus
);
    if (SETUP_CYCLES < 1 || SETUP_CYCLES > 15) begin : g_bad_setup
        $error("SETUP_CYCLES must be in 1..15");
    end
    if (STROBE_CYCLES < 1 || STROBE_CYCLES > 15) begin : g_bad_strobe
        $error("STROBE_CYCLES must be in 1..15");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("HOLD_CYCLES must be in 1..15");
    end

    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        is_write;
    logic [1:0]  addr_q;
    logic        cs_n_q;
    logic        r_n_q;
    logic        w_n_q;
    logic [15:0] data_out_q;
    logic        data_oe_q;
    logic [15:0] readdata_q;

    // Strobes only move while cs_n is already low, so they never share an edge with cs_n.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            is_write   <= 1'b0;
            addr_q     <= 2'd0;
            cs_n_q     <= 1'b1;
            r_n_q      <= 1'b1;
            w_n_q      <= 1'b1;
            data_out_q <= 16'd0;
            data_oe_q  <= 1'b0;
            readdata_q <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.chipselect && (bus.read || bus.write)) begin
                        is_write   <= bus.write;
                        addr_q     <= bus.address;
                        data_out_q <= bus.writedata[15:0];
                        data_oe_q  <= bus.write;
                        cs_n_q     <= 1'b0;
                        cnt        <= SETUP_LOAD;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == 4'd0) begin
                        r_n_q <= is_write;
                        w_n_q <= !is_write;
                        cnt   <= STROBE_LOAD;
                        state <= STROBE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt == 4'd0) begin
                        if (!is_write) begin
                            readdata_q <= bus.otg_hpi_data_in;
                        end
                        r_n_q <= 1'b1;
                        w_n_q <= 1'b1;
                        cnt   <= HOLD_LOAD;
                        state <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 4'd0) begin
                        cs_n_q    <= 1'b1;
                        data_oe_q <= 1'b0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.waitrequest      = reset ? 1'b1
                                : (bus.chipselect && (bus.read || bus.write) && state != DONE);
    assign bus.readdata         = {16'd0, readdata_q};
    assign bus.otg_hpi_address  = addr_q;
    assign bus.otg_hpi_cs_n     = cs_n_q;
    assign bus.otg_hpi_r_n      = r_n_q;
    assign bus.otg_hpi_w_n      = w_n_q;
    assign bus.otg_hpi_data_out = data_out_q;
    assign bus.otg_hpi_data_oe  = data_oe_q;
    assign bus.fsm_state        = state;

`ifdef OTG_HPI_INT_SYNC_EN
    logic int_meta;
    logic int_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            int_meta <= 1'b0;
            int_sync <= 1'b0;
        end else begin
            int_meta <= bus.otg_hpi_int;
            int_sync <= int_meta;
        end
    end

    assign bus.irq = int_sync;
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.writedata[31:16]};
`else
    assign bus.irq = 1'b0;
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.otg_hpi_int, bus.writedata[31:16]};
`endif
endmodule
